// File: rtl/nds_hs_pkg.sv
// rtl/nds_hs_pkg.sv - shared state encoding and defaults for the 4-phase request sender
package nds_hs_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_REQ     = REQ,
    S_RELEASE = RELEASE
  } hs_state_e;

endpackage

// File: rtl/nds_hs_ack_sync.sv
// rtl/nds_hs_ack_sync.sv - multi-flop synchronizer for the receiver acknowledge level
module nds_hs_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic b_clk,
  input  logic b_reset_n,
  input  logic a_ack,
  output logic b_ack_s
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift chain resets to 1 so the sender treats the receiver as busy until a low ack is seen
  always_ff @(posedge b_clk or negedge b_reset_n) begin
    if (!b_reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a_ack};
    end
  end

  assign b_ack_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/nds_hs_req_send.sv
// rtl/nds_hs_req_send.sv - sender side of a 4-phase req/ack crossing with one-entry pending buffer
module nds_hs_req_send
  import nds_hs_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  b_clk,
  input  logic                  b_reset_n,
  input  logic                  b_send,
  input  logic [DATA_WIDTH-1:0] b_data_in,
  output logic                  b_ready,
  output logic                  b_busy,
  output logic                  b_done,
  output logic                  b_overflow,
  input  logic                  b_overflow_clr,
  output logic                  a_req,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_ack
);

  hs_state_e             r_state;
  hs_state_e             w_state_nxt;
  logic                  r_pend_valid;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic [DATA_WIDTH-1:0] r_a_data;
  logic                  r_a_req;
  logic                  r_done;
  logic                  r_overflow;

  logic                  w_ack_s;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_load_new;
  logic                  w_load_pend;
  logic                  w_fill_pend;
  logic                  w_done_nxt;

  nds_hs_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .b_clk     (b_clk),
    .b_reset_n (b_reset_n),
    .a_ack     (a_ack),
    .b_ack_s   (w_ack_s)
  );

  // Ready depends only on registered state, so a_ack never reaches an output combinationally
  assign w_ready  = !r_pend_valid && !(r_state == S_IDLE && w_ack_s);
  assign w_accept = b_send && w_ready;
  assign w_drop   = b_send && !w_ready;

  // State register
  always_ff @(posedge b_clk or negedge b_reset_n) begin
    if (!b_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath controls; a pending entry left in IDLE launches as soon as ack is low
  always_comb begin
    w_state_nxt = r_state;
    w_load_new  = 1'b0;
    w_load_pend = 1'b0;
    w_fill_pend = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_valid && !w_ack_s) begin
          w_state_nxt = S_REQ;
          w_load_pend = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_REQ;
          w_load_new  = 1'b1;
        end
      end
      S_REQ: begin
        w_fill_pend = w_accept;
        if (w_ack_s) begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_fill_pend = w_accept;
        if (!w_ack_s) begin
          w_done_nxt = 1'b1;
          if (r_pend_valid) begin
            w_state_nxt = S_REQ;
            w_load_pend = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Payload and pending buffer; a_data only moves on an edge that enters REQ
  always_ff @(posedge b_clk or negedge b_reset_n) begin
    if (!b_reset_n) begin
      r_a_data     <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_load_new) begin
        r_a_data <= b_data_in;
      end else if (w_load_pend) begin
        r_a_data <= r_pend_data;
      end
      if (w_fill_pend) begin
        r_pend_data  <= b_data_in;
        r_pend_valid <= 1'b1;
      end else if (w_load_pend) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Registered request level and completion pulse
  always_ff @(posedge b_clk or negedge b_reset_n) begin
    if (!b_reset_n) begin
      r_a_req <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_a_req <= (w_state_nxt == S_REQ);
      r_done  <= w_done_nxt;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge b_clk or negedge b_reset_n) begin
    if (!b_reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (b_overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign b_ready    = w_ready;
  assign b_busy     = (r_state != S_IDLE);
  assign b_done     = r_done;
  assign b_overflow = r_overflow;
  assign a_req      = r_a_req;
  assign a_data     = r_a_data;

endmodule

// File: doc/nds_hs_req_send.md
NDS_HS_REQ_SEND -- requirements
Module: nds_hs_req_send

Interface
REQ-001 Parameter DATA_WIDTH, 32: width of the b_data_in and a_data payload.
REQ-002 Parameter SYNC_STAGES, 2: flop count on the a_ack synchronizer, minimum 2.
REQ-003 b_clk  input  1  sender clock; all logic in this block is clocked on its rising edge.
REQ-004 b_reset_n  input  1  reset: asynchronous, active-low.
REQ-005 b_send  input  1  one-cycle request to transfer b_data_in.
REQ-006 b_data_in  input  DATA_WIDTH  payload, sampled when b_send && b_ready.
REQ-007 b_ready  output  1  block can accept b_send this cycle (combinational).
REQ-008 b_busy  output  1  a handshake is in progress (state != IDLE).
REQ-009 b_done  output  1  one-cycle pulse on handshake completion.
REQ-010 b_overflow  output  1  sticky flag: a b_send was dropped.
REQ-011 b_overflow_clr  input  1  clears b_overflow.
REQ-012 a_req  output  1  registered 4-phase request level to the receiving domain.
REQ-013 a_data  output  DATA_WIDTH  registered payload, stable whenever a_req=1 or the synchronized ack=1.
REQ-014 a_ack  input  1  asynchronous acknowledge level from the receiver.

Function
REQ-015 a_ack SHALL pass through SYNC_STAGES flops to form ack_s; there SHALL be no other use of raw a_ack.
REQ-016 FSM states SHALL be IDLE, REQ and RELEASE.
REQ-017 A one-entry pending buffer (pend_valid, pend_data) SHALL hold one request accepted while busy.
REQ-018 b_ready SHALL equal !pend_valid && !(state==IDLE && ack_s).
REQ-019 b_send with b_ready=1 in IDLE SHALL load a_data from b_data_in and enter REQ, with a_req=1 on the next edge (latency 1).
REQ-020 b_send with b_ready=1 in REQ/RELEASE SHALL store b_data_in in the pending buffer.
REQ-021 b_send with b_ready=0 SHALL be dropped: set b_overflow, with no change to a_data or pend_data.
REQ-022 REQ -> RELEASE when ack_s=1; a_req SHALL go to 0 on that edge.
REQ-023 RELEASE exits when ack_s=0 and SHALL pulse b_done for exactly one cycle on that edge.
REQ-024 On RELEASE exit with pend_valid=1: load a_data from pend_data, clear pend_valid, enter REQ, and assert a_req on the same edge.
REQ-025 On RELEASE exit with pend_valid=0, the FSM SHALL enter IDLE.
REQ-026 a_data SHALL change only on an edge where the FSM enters REQ.
REQ-027 Same-cycle b_overflow set and b_overflow_clr: set SHALL win.
REQ-028 With a_ack stable, a_req SHALL rise-to-fall in SYNC_STAGES+1 b_clk edges after the a_ack rise, and b_done SHALL fire SYNC_STAGES+1 edges after the a_ack fall.

Reset
REQ-029 Reset values SHALL be: a_req=0, a_data=0, b_done=0, b_overflow=0, pend_valid=0, pend_data=0, state=IDLE.
REQ-030 Synchronizer flops SHALL reset to 1, so that b_ready=0 until a_ack low is seen.
REQ-031 Reset mid-handshake SHALL abandon the transfer and drop the pending entry, with no b_done.

Structure
REQ-032 Shared package nds_hs_pkg SHALL hold the state encoding localparams (IDLE=2'd0, REQ=2'd1, RELEASE=2'd2) and the DATA_WIDTH default.
REQ-033 The ack synchronizer SHALL be sub-module nds_hs_ack_sync (parameter SYNC_STAGES, reset value 1, ports b_clk, b_reset_n, a_ack, b_ack_s).
REQ-034 The block SHALL contain no combinational path from a_ack to any output.

Verification
REQ-035 Reset release with a_ack=0 -> b_ready=0 for 2 cycles, then 1; a_req=0 and a_data=0 throughout.
REQ-036 b_send with b_data_in=32'hA5A5_0001 in IDLE -> a_req=1 next edge; stimulus drives a_ack=1, then a_req=0 three edges later; stimulus drives a_ack=0, then b_done pulses once three edges later; a_data=32'hA5A5_0001 throughout.
REQ-037 b_send 32'h11, then b_send 32'h22 while in REQ -> pend_valid=1 and b_ready=0; on completion of 32'h11, a_data=32'h22 and a_req=1 on the b_done edge.
REQ-038 Third b_send 32'h33 while pending is full -> b_overflow=1 and 32'h33 never appears on a_data; b_overflow_clr asserted with a simultaneous drop -> b_overflow stays 1.
REQ-039 Reset asserted in REQ with a_ack=1 held -> a_req=0 and b_ready=0 until a_ack=0 is synchronized; a following b_send -> normal handshake.
REQ-040 Randomized a_ack delays of 0-20 cycles over 1000 transfers -> a_data is never changed while a_req=1 or ack_s=1, and the b_done count equals the accepted-send count.
